// File: rtl/hud_text_writer.sv
// HUD text writer: keeps the score digits, the lives digit and a banner field in a
// character RAM up to date. Each item is rewritten only when its value changes.
module hud_text_writer #(
   parameter int SCORE_ADDR = 7,
   parameter int LIVES_ADDR = 32,
   parameter int MSG_ADDR   = 64,
   parameter int MSG_LEN    = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [9:0] score,
   input  logic [3:0] lives,
   input  logic       msg_req,
   input  logic [1:0] msg_sel,
   output logic       ram_we,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_data,
   output logic       busy,
   output logic       msg_ack,
   output logic [2:0] dbg_state
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] CONV     = 3'd1;
   localparam logic [2:0] WR_SCORE = 3'd2;
   localparam logic [2:0] WR_LIVES = 3'd3;
   localparam logic [2:0] WR_MSG   = 3'd4;

   localparam logic [7:0] SCORE_A = 8'(SCORE_ADDR);
   localparam logic [7:0] LIVES_A = 8'(LIVES_ADDR);
   localparam logic [7:0] MSG_A   = 8'(MSG_ADDR);
   localparam logic [7:0] MSG_N   = 8'(MSG_LEN);

   logic [2:0] state;
   logic [9:0] score_sat, last_score, rem;
   logic [3:0] last_lives, hundreds, tens, ones;
   logic       score_pend, lives_pend, msg_pend;
   logic [1:0] msg_sel_q, cur_sel;
   logic [7:0] idx;

   assign score_sat = (score > 10'd999) ? 10'd999 : score;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [7:0] i);
      logic [7:0] c;
      c = 8'h00;
      case (sel)
         2'd1: case (i)
            8'd0: c = 8'h52; 8'd1: c = 8'h45; 8'd2: c = 8'h41;
            8'd3: c = 8'h44; 8'd4: c = 8'h59; 8'd5: c = 8'h21;
            default: c = 8'h00;
         endcase
         2'd2: case (i)
            8'd0: c = 8'h47; 8'd1: c = 8'h41; 8'd2: c = 8'h4D;
            8'd3: c = 8'h45; 8'd4: c = 8'h20; 8'd5: c = 8'h4F;
            8'd6: c = 8'h56; 8'd7: c = 8'h45; 8'd8: c = 8'h52;
            default: c = 8'h00;
         endcase
         2'd3: case (i)
            8'd0: c = 8'h59; 8'd1: c = 8'h4F; 8'd2: c = 8'h55;
            8'd3: c = 8'h20; 8'd4: c = 8'h57; 8'd5: c = 8'h49;
            8'd6: c = 8'h4E;
            default: c = 8'h00;
         endcase
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         ram_we     <= 1'b0;
         ram_addr   <= 8'd0;
         ram_data   <= 8'd0;
         msg_ack    <= 1'b0;
         msg_pend   <= 1'b0;
         score_pend <= 1'b1;
         lives_pend <= 1'b1;
         last_score <= 10'd0;
         last_lives <= 4'd0;
         rem        <= 10'd0;
         hundreds   <= 4'd0;
         tens       <= 4'd0;
         ones       <= 4'd0;
         idx        <= 8'd0;
         msg_sel_q  <= 2'd0;
         cur_sel    <= 2'd0;
      end else begin
         ram_we  <= 1'b0;
         msg_ack <= 1'b0;
         // Change detection first so a service in this cycle can clear the flag.
         if (score_sat != last_score) score_pend <= 1'b1;
         if (lives != last_lives)     lives_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (msg_pend) begin
                  msg_pend <= 1'b0;
                  cur_sel  <= msg_sel_q;
                  ram_we   <= 1'b1;
                  ram_addr <= MSG_A;
                  ram_data <= msg_char(msg_sel_q, 8'd0);
                  idx      <= 8'd1;
                  state    <= WR_MSG;
               end else if (score_pend) begin
                  score_pend <= 1'b0;
                  rem        <= score_sat;
                  last_score <= score_sat;
                  hundreds   <= 4'd0;
                  tens       <= 4'd0;
                  ones       <= 4'd0;
                  state      <= CONV;
               end else if (lives_pend) begin
                  lives_pend <= 1'b0;
                  last_lives <= lives;
                  ram_we     <= 1'b1;
                  ram_addr   <= LIVES_A;
                  ram_data   <= (lives > 4'd9) ? 8'h39 : 8'h30 + {4'd0, lives};
                  state      <= WR_LIVES;
               end
            end
            CONV: begin
               if (rem >= 10'd100) begin
                  rem      <= rem - 10'd100;
                  hundreds <= hundreds + 4'd1;
               end else if (rem >= 10'd10) begin
                  rem  <= rem - 10'd10;
                  tens <= tens + 4'd1;
               end else begin
                  ones     <= rem[3:0];
                  ram_we   <= 1'b1;
                  ram_addr <= SCORE_A;
                  ram_data <= 8'h30 + {4'd0, hundreds};
                  idx      <= 8'd1;
                  state    <= WR_SCORE;
               end
            end
            WR_SCORE: begin
               if (idx == 8'd3) begin
                  state <= IDLE;
               end else begin
                  ram_we   <= 1'b1;
                  ram_addr <= SCORE_A + idx;
                  ram_data <= 8'h30 + {4'd0, (idx == 8'd1) ? tens : ones};
                  idx      <= idx + 8'd1;
               end
            end
            WR_LIVES: state <= IDLE;
            WR_MSG: begin
               if (idx == MSG_N) begin
                  msg_ack <= 1'b1;
                  state   <= IDLE;
               end else begin
                  ram_we   <= 1'b1;
                  ram_addr <= MSG_A + idx;
                  ram_data <= msg_char(cur_sel, idx);
                  idx      <= idx + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase

         // A request in the same cycle as a service stays pending; latest select wins.
         if (msg_req) begin
            msg_pend  <= 1'b1;
            msg_sel_q <= msg_sel;
         end
      end
   end

endmodule

// File: tb/tb_hud_text_writer.sv
// Bench for hud_text_writer: RAM writes are matched in order against an expected
// queue; score/lives tables plus hand sequences for banner, preemption and reset.
module tb_hud_text_writer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [9:0] score;
   logic [3:0] lives;
   logic       msg_req;
   logic [1:0] msg_sel;
   logic       ram_we;
   logic [7:0] ram_addr, ram_data;
   logic       busy, msg_ack;
   logic [2:0] dbg_state;

   hud_text_writer dut (
      .Clk(Clk), .Reset(Reset), .score(score), .lives(lives),
      .msg_req(msg_req), .msg_sel(msg_sel), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy),
      .msg_ack(msg_ack), .dbg_state(dbg_state)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_e;
   int wr_cnt = 0;
   int conv_cnt = 0;
   int ack_cnt = 0;
   logic prev_we = 1'b0;
   logic [7:0] prev_addr = 8'd0;

   typedef struct {
      logic [9:0] score;
      logic [3:0] h, t, o;
      int         conv;
      bit         wr;
   } svec_t;

   typedef struct {
      logic [3:0] lives;
      logic [7:0] ch;
      bit         wr;
   } lvec_t;

   svec_t svecs[8];
   lvec_t lvecs[6];

   task automatic check(input string name, input int got, input int expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, expv);
      end
   endtask

   function automatic logic [7:0] banner(input int sel, input int i);
      string s;
      case (sel)
         1: s = "READY!";
         2: s = "GAME OVER";
         3: s = "YOU WIN";
         default: s = "";
      endcase
      if (i < s.len()) return s[i];
      return 8'h00;
   endfunction

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic push_score(input int v);
      int s;
      s = (v > 999) ? 999 : v;
      push_wr(8'd7, 8'(8'h30 + s / 100));
      push_wr(8'd8, 8'(8'h30 + (s / 10) % 10));
      push_wr(8'd9, 8'(8'h30 + s % 10));
   endtask

   task automatic push_banner(input int sel, input int n);
      for (int i = 0; i < n; i++) push_wr(8'(64 + i), banner(sel, i));
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      int quiet = 0;
      while (n < budget && quiet < 6) begin
         @(negedge Clk); #1;
         n++;
         if (exp_q.size() == 0 && !busy) quiet++;
         else quiet = 0;
      end
      if (quiet < 6) begin
         tests++;
         fails++;
         $display("FAIL timeout: %0d writes still expected after %0d cycles", exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   always @(negedge Clk) begin
      if (ram_we) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr=%0d data=%h, none expected", ram_addr, ram_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({ram_addr, ram_data} !== mon_e) begin
               fails++;
               $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                        ram_addr, ram_data, mon_e[15:8], mon_e[7:0]);
            end
         end
         wr_cnt++;
      end else if (busy) begin
         conv_cnt++;
      end
      if (msg_ack) begin
         ack_cnt++;
         tests++;
         if (!(prev_we && prev_addr == 8'd73 && !ram_we)) begin
            fails++;
            $display("FAIL msg_ack_timing: prev_we=%0b prev_addr=%0d we=%0b, required 1/73/0",
                     prev_we, prev_addr, ram_we);
         end
      end
      prev_we   = ram_we;
      prev_addr = ram_addr;
   end

   initial begin
      int ack0, w0, lat, n;

      svecs[0] = '{10'd347,  4'd3, 4'd4, 4'd7, 8,  1'b1};
      svecs[1] = '{10'd1023, 4'd9, 4'd9, 4'd9, 19, 1'b1};
      svecs[2] = '{10'd1000, 4'd9, 4'd9, 4'd9, 0,  1'b0};
      svecs[3] = '{10'd5,    4'd0, 4'd0, 4'd5, 1,  1'b1};
      svecs[4] = '{10'd100,  4'd1, 4'd0, 4'd0, 2,  1'b1};
      svecs[5] = '{10'd90,   4'd0, 4'd9, 4'd0, 10, 1'b1};
      svecs[6] = '{10'd999,  4'd9, 4'd9, 4'd9, 19, 1'b1};
      svecs[7] = '{10'd0,    4'd0, 4'd0, 4'd0, 1,  1'b1};

      lvecs[0] = '{4'd1,  8'h31, 1'b1};
      lvecs[1] = '{4'd9,  8'h39, 1'b1};
      lvecs[2] = '{4'd15, 8'h39, 1'b1};
      lvecs[3] = '{4'd10, 8'h39, 1'b1};
      lvecs[4] = '{4'd10, 8'h39, 1'b0};
      lvecs[5] = '{4'd2,  8'h32, 1'b1};

      // Reset state and post-reset refresh
      Reset = 1'b1; score = 10'd0; lives = 4'd2; msg_req = 1'b0; msg_sel = 2'd0;
      repeat (3) @(negedge Clk);
      #1;
      check("reset_we", ram_we, 0);
      check("reset_addr", ram_addr, 0);
      check("reset_data", ram_data, 0);
      check("reset_busy", busy, 0);
      check("reset_ack", msg_ack, 0);
      push_score(0);
      push_wr(8'd32, 8'h32);
      conv_cnt = 0;
      Reset = 1'b0;
      wait_done(200);
      check("refresh_conv", conv_cnt, 1);
      check("refresh_busy", busy, 0);

      // Score table
      for (int i = 0; i < 8; i++) begin
         conv_cnt = 0;
         if (svecs[i].wr) begin
            push_wr(8'd7, 8'h30 + {4'd0, svecs[i].h});
            push_wr(8'd8, 8'h30 + {4'd0, svecs[i].t});
            push_wr(8'd9, 8'h30 + {4'd0, svecs[i].o});
         end
         score = svecs[i].score;
         wait_done(300);
         check($sformatf("conv_len_%0d", svecs[i].score), conv_cnt, svecs[i].conv);
      end

      // Lives table with first-write latency
      for (int i = 0; i < 6; i++) begin
         if (lvecs[i].wr) push_wr(8'd32, lvecs[i].ch);
         w0 = wr_cnt;
         lives = lvecs[i].lives;
         lat = 0;
         while (wr_cnt == w0 && lat < 20) begin
            @(negedge Clk); #1;
            lat++;
         end
         if (lvecs[i].wr) check($sformatf("lives_lat_%0d", lvecs[i].lives), lat, 2);
         else check("lives_nochange_writes", wr_cnt - w0, 0);
         wait_done(100);
      end

      // Banner and score change in the same cycle: banner first
      push_banner(2, 10);
      push_score(456);
      ack0 = ack_cnt;
      score = 10'd456; msg_req = 1'b1; msg_sel = 2'd2;
      @(negedge Clk); #1;
      msg_req = 1'b0;
      wait_done(400);
      check("gameover_ack_count", ack_cnt - ack0, 1);

      // Changes during a score sequence; latest banner request wins
      push_score(789);
      push_banner(3, 10);
      push_wr(8'd32, 8'h31);
      ack0 = ack_cnt;
      score = 10'd789;
      repeat (3) @(negedge Clk);
      #1;
      check("busy_in_conv", busy, 1);
      lives = 4'd1; msg_req = 1'b1; msg_sel = 2'd1;
      @(negedge Clk); #1;
      msg_req = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      msg_req = 1'b1; msg_sel = 2'd3;
      @(negedge Clk); #1;
      msg_req = 1'b0;
      wait_done(400);
      check("youwin_ack_count", ack_cnt - ack0, 1);

      // Reset during the 4th banner write
      push_score(0);
      push_wr(8'd32, 8'h32);
      score = 10'd0; lives = 4'd2;
      wait_done(300);
      push_banner(1, 4);
      ack0 = ack_cnt;
      w0 = wr_cnt;
      msg_req = 1'b1; msg_sel = 2'd1;
      @(negedge Clk); #1;
      msg_req = 1'b0;
      n = 0;
      while (wr_cnt - w0 < 4 && n < 50) begin
         @(negedge Clk); #1;
         n++;
      end
      check("banner_writes_before_reset", wr_cnt - w0, 4);
      Reset = 1'b1;
      push_score(0);
      push_wr(8'd32, 8'h32);
      @(negedge Clk); #1;
      check("midreset_we", ram_we, 0);
      check("midreset_busy", busy, 0);
      Reset = 1'b0;
      wait_done(300);
      check("midreset_ack_count", ack_cnt - ack0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hud_text_writer.md
HUD_TEXT_WRITER -- requirements
Module: hud_text_writer

Interface
REQ-001 Parameter SCORE_ADDR, default 7: text-RAM address of the score hundreds digit; tens and ones follow at +1 and +2.
REQ-002 Parameter LIVES_ADDR, default 32: text-RAM address of the lives digit.
REQ-003 Parameter MSG_ADDR, default 64: first text-RAM address of the banner field.
REQ-004 Parameter MSG_LEN, default 10: banner field length in characters.
REQ-005 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 score  input  10  game score, binary; values >999 display as 999.
REQ-008 lives  input  4  lives remaining; values >9 display as 9.
REQ-009 msg_req  input  1  one-cycle request to write a banner.
REQ-010 msg_sel  input  2  banner select, sampled with msg_req: 0 blank, 1 "READY!", 2 "GAME OVER", 3 "YOU WIN".
REQ-011 ram_we  output  1  text-RAM write enable.
REQ-012 ram_addr  output  8  text-RAM write address.
REQ-013 ram_data  output  8  text-RAM write data, ASCII.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 msg_ack  output  1  one-cycle pulse when the last banner character is written.

Function
REQ-016 FSM states: IDLE, CONV, WR_SCORE, WR_LIVES, WR_MSG; ram_we, ram_addr, and ram_data are registered outputs.
REQ-017 Pending flags: score_pend sets when score differs from last_score, lives_pend when lives differs from last_lives, msg_pend on msg_req.
REQ-018 In IDLE, service order is msg_pend, then score_pend, then lives_pend; a started sequence is never preempted.
REQ-019 A msg_req arriving while msg_pend is already set overwrites the latched msg_sel; the latest request wins.
REQ-020 At score service: latch the saturated score into rem and last_score, clear score_pend, clear the digit counters, enter CONV.
REQ-021 CONV does one step per cycle: if rem>=100, subtract 100 and increment hundreds; else if rem>=10, subtract 10 and increment tens; else ones=rem and go to WR_SCORE.
REQ-022 CONV occupies hundreds+tens+1 cycles; maximum 19 cycles.
REQ-023 WR_SCORE writes 0x30+hundreds, 0x30+tens, and 0x30+ones to SCORE_ADDR, +1, and +2 on 3 consecutive cycles, then returns to IDLE.
REQ-024 At lives service: latch lives, clear lives_pend, and write 0x30+min(lives,9) to LIVES_ADDR for exactly 1 cycle (WR_LIVES).
REQ-025 At message service: clear msg_pend and write MSG_LEN characters to MSG_ADDR..MSG_ADDR+MSG_LEN-1, one per cycle, in ascending order (WR_MSG).
REQ-026 Banner strings are left-aligned and padded with 0x00; "READY!"=52 45 41 44 59 21, "GAME OVER"=47 41 4D 45 20 4F 56 45 52, "YOU WIN"=59 4F 55 20 57 49 4E, blank = all 0x00.
REQ-027 msg_ack is asserted in the cycle after the final WR_MSG write, concurrently with the return to IDLE.
REQ-028 Score or lives changes during any sequence set the corresponding pend flag; they are serviced later, using the value sampled at service time.
REQ-029 ram_we is low in IDLE and CONV; each written character asserts ram_we for exactly 1 cycle.
REQ-030 IDLE to first write latency: score = CONV length + 1 cycle; lives = 1 cycle; message = 1 cycle.
REQ-031 Address arithmetic is 8-bit; MSG_ADDR+MSG_LEN-1 <= 255 is a parameter constraint and is not checked.

Reset
REQ-032 Reset takes priority over all other activity: state=IDLE, ram_we=0, ram_addr=0, ram_data=0, busy=0, msg_ack=0, msg_pend=0.
REQ-033 Reset sets last_score=0, last_lives=0, score_pend=1, lives_pend=1, so that score "000" and the lives digit are rewritten after reset.
REQ-034 Reset asserted mid-sequence abandons the sequence with no further writes; the partial RAM contents are overwritten by the REQ-033 refresh.

Verification
REQ-035 Release reset with score=0 and lives=2 -> writes 0x30,0x30,0x30 to addresses 7,8,9, then 0x32 to address 32; busy drops.
REQ-036 score changes 0->347 in IDLE -> CONV lasts 8 cycles, then writes 0x33,0x34,0x37 to addresses 7..9 on consecutive cycles.
REQ-037 score=1023 -> writes 0x39,0x39,0x39; CONV lasts 19 cycles.
REQ-038 msg_req with msg_sel=2 issued in the same cycle that score changes -> 10 banner writes to 64..73 (47 41 4D 45 20 4F 56 45 52 00), msg_ack pulses once, then the score sequence runs.
REQ-039 During a score sequence, lives changes 2->1 and msg_req is given twice (sel=1 then sel=3) -> after the score sequence, exactly one "YOU WIN" banner is written, then 0x31 to address 32.
REQ-040 Reset asserted in the 4th WR_MSG cycle -> ram_we=0 on the next cycle, no msg_ack, then the REQ-035 refresh sequence runs.
